// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the dm_4k two-port arbiter:
// FSM encodings and default bus widths.
package dm_arbiter_pkg;

    localparam int DM_AW = 10;
    localparam int DM_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        RESP = 2'd3
    } state_t;

    function automatic logic is_gnt(input state_t s);
        return (s == GNT0) || (s == GNT1);
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Two-way round-robin pick: on a tie the port
// that was not granted last wins.
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_sel
);

    assign gnt_valid = req0 | req1;
    assign gnt_sel   = (req0 & req1) ? ~last_gnt : req1;

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates CPU (port 0) and DMA/debug (port 1)
// accesses onto a single dm_4k memory.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int AW = DM_AW,
    parameter int DW = DM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [3:0]    be0,
    input  logic [DW-1:0] wd0,
    output logic          ack0,
    output logic [DW-1:0] rd0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [3:0]    be1,
    input  logic [DW-1:0] wd1,
    output logic          ack1,
    output logic [DW-1:0] rd1,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          cap_we_q, cap_we_d;
    logic [AW-1:0] cap_addr_q, cap_addr_d;
    logic [3:0]    cap_be_q, cap_be_d;
    logic [DW-1:0] cap_wd_q, cap_wd_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          pick_req0, pick_req1;
    logic          gnt_valid, gnt_sel;
    logic          in_gnt;

    // In RESP the port just served is masked out
    assign pick_req0 = req0 & !(state_q == RESP && !last_q);
    assign pick_req1 = req1 & !(state_q == RESP && last_q);

    rr_pick u_pick (
        .req0      (pick_req0),
        .req1      (pick_req1),
        .last_gnt  (last_q),
        .gnt_valid (gnt_valid),
        .gnt_sel   (gnt_sel)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cap_we_d   = cap_we_q;
        cap_addr_d = cap_addr_q;
        cap_be_d   = cap_be_q;
        cap_wd_d   = cap_wd_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rd0_d      = rd0_q;
        rd1_d      = rd1_q;
        unique case (state_q)
            IDLE, RESP: begin
                if (gnt_valid) begin
                    state_d    = gnt_sel ? GNT1 : GNT0;
                    last_d     = gnt_sel;
                    cap_we_d   = gnt_sel ? we1 : we0;
                    cap_addr_d = gnt_sel ? addr1 : addr0;
                    cap_be_d   = gnt_sel ? be1 : be0;
                    cap_wd_d   = gnt_sel ? wd1 : wd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                rd0_d   = mem_rd;
                ack0_d  = 1'b1;
                state_d = RESP;
            end
            GNT1: begin
                rd1_d   = mem_rd;
                ack1_d  = 1'b1;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cap_we_q   <= 1'b0;
            cap_addr_q <= '0;
            cap_be_q   <= '0;
            cap_wd_q   <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rd0_q      <= '0;
            rd1_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cap_we_q   <= cap_we_d;
            cap_addr_q <= cap_addr_d;
            cap_be_q   <= cap_be_d;
            cap_wd_q   <= cap_wd_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rd0_q      <= rd0_d;
            rd1_q      <= rd1_d;
        end
    end

    assign in_gnt   = is_gnt(state_q);
    assign mem_addr = cap_addr_q;
    assign mem_wd   = cap_wd_q;
    assign mem_be   = in_gnt ? cap_be_q : 4'h0;
    assign mem_we   = in_gnt & cap_we_q;

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign rd0  = rd0_q;
    assign rd1  = rd1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter with a dm_4k model and a
// transaction-level reference memory.
`timescale 1ns/1ps
module tb_dm_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [3:0]    be0, be1;
    logic [DW-1:0] wd0, wd1;
    logic          ack0, ack1;
    logic [DW-1:0] rd0, rd1;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .be0(be0),
        .wd0(wd0), .ack0(ack0), .rd0(rd0),
        .req1(req1), .we1(we1), .addr1(addr1), .be1(be1),
        .wd1(wd1), .ack1(ack1), .rd1(rd1),
        .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    // dm_4k model: combinational read, byte-masked write
    assign mem_rd = mem[mem_addr];
    always @(posedge clk)
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_be[b])
                    mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o,
                                            input logic [DW-1:0] w,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic set_port(input int p, input logic we,
                            input logic [AW-1:0] a,
                            input logic [3:0] be,
                            input logic [DW-1:0] wd);
        if (p == 0) begin
            req0 = 1'b1; we0 = we; addr0 = a; be0 = be; wd0 = wd;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = a; be1 = be; wd1 = wd;
        end
    endtask

    task automatic clr_port(input int p);
        if (p == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic access(input int p, input logic we,
                          input logic [AW-1:0] a,
                          input logic [3:0] be,
                          input logic [DW-1:0] wd,
                          output logic [DW-1:0] rdata,
                          output int lat);
        @(negedge clk);
        set_port(p, we, a, be, wd);
        lat = -1;
        rdata = '0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if ((p == 0) ? ack0 : ack1) begin
                lat = c;
                rdata = (p == 0) ? rd0 : rd1;
                break;
            end
        end
        clr_port(p);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({ack0, ack1, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: ack0/ack1/we=%b want 000",
                     {ack0, ack1, mem_we});
        end
        checks++;
        if (rd0 !== '0 || rd1 !== '0) begin
            errors++;
            $display("FAIL reset_rd: rd0=%h rd1=%h want 0", rd0, rd1);
        end
        checks++;
        if (mem_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_be: got %h want 0", mem_be);
        end
    endtask

    task automatic test_lone_write();
        logic [DW-1:0] r;
        int lat;
        @(negedge clk);
        set_port(0, 1'b1, 10'h004, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 10'h004 ||
            mem_be !== 4'hF || mem_wd !== 32'hDEADBEEF || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL lone_gnt: we=%b a=%h be=%h wd=%h ack=%b want 1 004 f deadbeef 0",
                     mem_we, mem_addr, mem_be, mem_wd, ack0);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL lone_ack: ack0=%b we=%b want 1 0", ack0, mem_we);
        end
        clr_port(0);
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL lone_pulse: ack0=%b we=%b want 0 0", ack0, mem_we);
        end
        access(1, 1'b0, 10'h004, 4'hF, '0, r, lat);
        checks++;
        if (r !== 32'hDEADBEEF || lat !== 2) begin
            errors++;
            $display("FAIL lone_readback: rd1=%h lat=%0d want deadbeef 2", r, lat);
        end
    endtask

    task automatic test_drop_after_grant();
        @(negedge clk);
        set_port(0, 1'b0, 10'h004, 4'hF, '0);
        @(negedge clk);
        clr_port(0);
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || rd0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL drop_after_grant: ack0=%b rd0=%h want 1 deadbeef",
                     ack0, rd0);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        mem[10'h008] <= 32'hA5A50008;
        mem[10'h009] <= 32'h5A5A0009;
        @(negedge clk);
        set_port(0, 1'b0, 10'h008, 4'hF, '0);
        set_port(1, 1'b0, 10'h009, 4'hF, '0);
        @(negedge clk);
        checks++;
        if (mem_addr !== 10'h008) begin
            errors++;
            $display("FAIL tie_first: mem_addr=%h want 008", mem_addr);
        end
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || rd0 !== 32'hA5A50008) begin
            errors++;
            $display("FAIL tie_ack0: ack0=%b ack1=%b rd0=%h want 1 0 a5a50008",
                     ack0, ack1, rd0);
        end
        clr_port(0);
        @(negedge clk);
        checks++;
        if (mem_addr !== 10'h009 || mem_be !== 4'hF || ack0 !== 1'b0) begin
            errors++;
            $display("FAIL tie_no_idle: a=%h be=%h ack0=%b want 009 f 0",
                     mem_addr, mem_be, ack0);
        end
        @(negedge clk);
        checks++;
        if (ack1 !== 1'b1 || rd1 !== 32'h5A5A0009) begin
            errors++;
            $display("FAIL tie_ack1: ack1=%b rd1=%h want 1 5a5a0009", ack1, rd1);
        end
        clr_port(1);
    endtask

    task automatic test_round_robin();
        int n, prev, prev_c;
        n = 0;
        prev = -1;
        prev_c = 0;
        @(negedge clk);
        set_port(0, 1'b0, 10'h008, 4'hF, '0);
        set_port(1, 1'b0, 10'h009, 4'hF, '0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ack0 && ack1) begin
                checks++;
                errors++;
                $display("FAIL rr_both: both acks at cycle %0d want one", c);
            end else if (ack0 || ack1) begin
                int who;
                who = ack1 ? 1 : 0;
                if (n > 0) begin
                    checks++;
                    if (who == prev || c - prev_c != 2) begin
                        errors++;
                        $display("FAIL rr_alt: port %0d gap %0d after port %0d want other gap 2",
                                 who, c - prev_c, prev);
                    end
                end
                checks++;
                if ((who == 0 && rd0 !== 32'hA5A50008) ||
                    (who == 1 && rd1 !== 32'h5A5A0009)) begin
                    errors++;
                    $display("FAIL rr_data: port %0d rd0=%h rd1=%h", who, rd0, rd1);
                end
                prev = who;
                prev_c = c;
                n++;
                if (n == 8) break;
            end
        end
        clr_port(0);
        clr_port(1);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL rr_count: %0d acks want 8", n);
        end
    endtask

    task automatic test_byte_write();
        logic [DW-1:0] r;
        int lat;
        access(0, 1'b1, 10'h014, 4'hF, 32'h11223344, r, lat);
        access(1, 1'b1, 10'h014, 4'b0010, 32'h0000AB00, r, lat);
        checks++;
        if (r !== 32'h11223344 || lat !== 2) begin
            errors++;
            $display("FAIL byte_old: rd1=%h lat=%0d want 11223344 2", r, lat);
        end
        access(0, 1'b0, 10'h014, 4'hF, '0, r, lat);
        checks++;
        if (r !== 32'h1122AB44) begin
            errors++;
            $display("FAIL byte_merge: rd0=%h want 1122ab44", r);
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] r;
        int lat;
        @(negedge clk);
        set_port(1, 1'b1, 10'h01E, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_gnt1: mem_we=%b want 1", mem_we);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || ack1 !== 1'b0 || mem_be !== 4'h0 || rd1 !== '0) begin
            errors++;
            $display("FAIL mid_async: we=%b ack1=%b be=%h rd1=%h want 0 0 0 0",
                     mem_we, ack1, mem_be, rd1);
        end
        clr_port(1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (ack1 !== 1'b0 || mem_be !== 4'h0 || rd1 !== '0) begin
                errors++;
                $display("FAIL mid_idle: ack1=%b be=%h rd1=%h want 0 0 0",
                         ack1, mem_be, rd1);
            end
        end
        access(0, 1'b0, 10'h008, 4'hF, '0, r, lat);
        checks++;
        if (lat !== 2 || r !== 32'hA5A50008) begin
            errors++;
            $display("FAIL mid_after: lat=%0d rd0=%h want 2 a5a50008", lat, r);
        end
    endtask

    task automatic test_withdraw();
        int acks, act;
        acks = 0;
        act = 0;
        @(negedge clk);
        set_port(0, 1'b0, 10'h008, 4'hF, '0);
        @(negedge clk);
        set_port(1, 1'b1, 10'h028, 4'hF, 32'h0BADF00D);
        @(negedge clk);
        clr_port(1);
        checks++;
        if (ack0 !== 1'b1) begin
            errors++;
            $display("FAIL wd_ack0: ack0=%b want 1", ack0);
        end
        clr_port(0);
        for (int c = 0; c < 6; c++) begin
            if (ack1) acks++;
            if (mem_be != 4'h0 || mem_we) act++;
            @(negedge clk);
        end
        checks++;
        if (acks !== 0 || act !== 0) begin
            errors++;
            $display("FAIL wd_none: ack1 count=%0d accesses=%0d want 0 0", acks, act);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [16];
        logic [AW-1:0] a0, a1;
        logic [3:0]    b0, b1;
        logic [DW-1:0] w0, w1, e0, e1, r, r0, r1;
        logic          we_0, we_1;
        int            last_srv, lat, p, c0, c1, win;
        last_srv = 0;
        for (int i = 0; i < 16; i++) begin
            logic [DW-1:0] v;
            pool[i] = AW'($urandom_range(64, (1 << AW) - 1));
            v = $urandom;
            mem[pool[i]] <= v;
            ref_mem[pool[i]] = v;
        end
        for (int it = 0; it < 60; it++) begin
            a0 = pool[$urandom_range(0, 15)];
            a1 = pool[$urandom_range(0, 15)];
            b0 = 4'($urandom_range(0, 15));
            b1 = 4'($urandom_range(0, 15));
            w0 = $urandom;
            w1 = $urandom;
            we_0 = 1'($urandom_range(0, 1));
            we_1 = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                p = $urandom_range(0, 1);
                if (p == 1) begin
                    a0 = a1; b0 = b1; w0 = w1; we_0 = we_1;
                end
                e0 = ref_mem[a0];
                if (we_0) ref_mem[a0] = merge(ref_mem[a0], w0, b0);
                access(p, we_0, a0, b0, w0, r, lat);
                checks++;
                if (lat !== 2 || r !== e0) begin
                    errors++;
                    $display("FAIL rnd_single: it %0d port %0d lat=%0d rd=%h want 2 %h",
                             it, p, lat, r, e0);
                end
                last_srv = p;
            end else begin
                win = 1 - last_srv;
                if (win == 0) begin
                    e0 = ref_mem[a0];
                    if (we_0) ref_mem[a0] = merge(ref_mem[a0], w0, b0);
                    e1 = ref_mem[a1];
                    if (we_1) ref_mem[a1] = merge(ref_mem[a1], w1, b1);
                end else begin
                    e1 = ref_mem[a1];
                    if (we_1) ref_mem[a1] = merge(ref_mem[a1], w1, b1);
                    e0 = ref_mem[a0];
                    if (we_0) ref_mem[a0] = merge(ref_mem[a0], w0, b0);
                end
                @(negedge clk);
                set_port(0, we_0, a0, b0, w0);
                set_port(1, we_1, a1, b1, w1);
                c0 = -1;
                c1 = -1;
                r0 = '0;
                r1 = '0;
                for (int c = 1; c <= 12; c++) begin
                    @(negedge clk);
                    if (ack0) begin c0 = c; r0 = rd0; clr_port(0); end
                    if (ack1) begin c1 = c; r1 = rd1; clr_port(1); end
                    if (c0 > 0 && c1 > 0) break;
                end
                clr_port(0);
                clr_port(1);
                checks++;
                if ((win == 0 && (c0 !== 2 || c1 !== 4)) ||
                    (win == 1 && (c1 !== 2 || c0 !== 4))) begin
                    errors++;
                    $display("FAIL rnd_order: it %0d ack0@%0d ack1@%0d winner %0d",
                             it, c0, c1, win);
                end
                checks++;
                if (r0 !== e0 || r1 !== e1) begin
                    errors++;
                    $display("FAIL rnd_pair_data: it %0d rd0=%h rd1=%h want %h %h",
                             it, r0, r1, e0, e1);
                end
                last_srv = 1 - win;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wd0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wd1 = '0;
        apply_reset();
        test_reset();
        test_lone_write();
        test_drop_after_grant();
        test_tie();
        test_round_robin();
        test_byte_write();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
